alu_exec_stage: RTL and testbench
=================================

# alu_exec_stage

Execute stage sitting directly downstream of the 64-bit, 32-entry register bank's read ports and upstream of its write port. It accepts an opcode plus two 64-bit operands (taken from the bank's `output_data1`/`output_data2`) and a 5-bit destination address, computes the result, and drives a registered one-cycle write-back pulse straight into the bank's `write`/`address3`/`input_data` port. Simple ALU ops complete in one cycle at full throughput; multiply runs on an iterative shift-add unit and stalls the input handshake until done.

## Interface
- `DATA_W`, 64, operand/result width
- `ADDR_W`, 5, register address width
- `clk`  input  1  rising-edge clock
- `rst`  input  1  reset; asynchronous, active-high
- `in_valid`  input  1  operation request valid
- `in_ready`  output  1  stage can accept a request this cycle
- `op`  input  4  opcode (see Operation)
- `operand_a`  input  DATA_W  first source (bank `output_data1`)
- `operand_b`  input  DATA_W  second source (bank `output_data2`)
- `dest_addr`  input  ADDR_W  destination register
- `wb_write`  output  1  write-back strobe → bank `write`
- `wb_address`  output  ADDR_W  → bank `address3`
- `wb_data`  output  DATA_W  → bank `input_data`
- `busy`  output  1  multiply in progress
- `illegal_op`  output  1  one-cycle pulse: rejected opcode

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU, 10 MUL; 11–15 illegal.
- Arithmetic modulo 2^64; no overflow/carry flags. Shift amount = `operand_b[5:0]`, upper bits ignored. SLT/SLTU result is 64-bit 0 or 1. MUL returns low 64 bits of the product (signedness irrelevant for low half).
- Transfer occurs when `in_valid && in_ready` at a rising edge; operands and `dest_addr` are captured on that edge.
- States: IDLE, MUL.
  - IDLE: `in_ready`=1. Simple op accepted → result registered onto wb outputs, `wb_write`=1 next cycle, stay IDLE. MUL accepted → load multiplier, counter=0, go MUL. Illegal op accepted → no write-back, `illegal_op`=1 next cycle, stay IDLE.
  - MUL: `in_ready`=0, `busy`=1; one multiplier bit per edge; on the edge with counter=63, register product onto wb outputs, `wb_write`=1 next cycle, go IDLE.
- `wb_write` is never held more than one cycle per operation; `wb_address`/`wb_data` hold last value when `wb_write`=0.
- `dest_addr` 0 is written like any other register (bank has no hardwired zero).

## Timing
- Reset values: `in_ready`=1, `wb_write`=0, `wb_address`=0, `wb_data`=0, `busy`=0, `illegal_op`=0; state IDLE, counter 0.
- Simple op: accepted at edge N → `wb_write` high in cycle after edge N (latency 1); back-to-back accepts give one write per cycle.
- MUL: accepted at edge N → iterations at edges N+1..N+64 → `wb_write` high after edge N+64; `in_ready` low from after edge N until that same cycle, when it is high again (next op may be accepted while MUL result is being written).
- Bank reads are combinational, so operands are valid in the same cycle as the request; read-after-write to a register written by this stage is resolved by the bank's edge update with no extra bypass.
- `rst` asserted mid-MUL: multiply aborted, no write-back, all outputs to reset values immediately.
- `in_valid` while `in_ready`=0: ignored, no capture.

## Configuration
- `ALU_EXEC_MUL_EN` defined: iterative multiplier and MUL state compiled in, behaviour as above.
- Not defined: no multiplier, no MUL state; opcode 10 treated as illegal (`illegal_op` pulse, no write-back); `busy` tied 0, `in_ready` tied 1 outside reset.

## Structure
- Shared package `alu_exec_pkg`: `DATA_W`/`ADDR_W` defaults, opcode enum (`OP_ADD`..`OP_MUL`), state enum.
- Sub-module `mul_iter`: 64-cycle shift-add multiplier with start/done, 6-bit counter, 64-bit accumulator; instantiated only under `ALU_EXEC_MUL_EN`.

## Test plan
- ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1, dest=3 → next cycle `wb_write`=1, `wb_address`=3, `wb_data`=0.
- SRA a=0x8000_0000_0000_0000, b=0x43 (amount 3) → `wb_data`=0xF000_0000_0000_0000; SLT a=-1, b=0 → 1; SLTU same → 0.
- MUL a=0x1_0000_0001, b=0x1_0000_0001, dest=7 → `in_ready`=0 for 64 cycles, then `wb_data`=0x2_0000_0001 written once to 7.
- Back-to-back ADD/XOR/SUB on three consecutive cycles → three consecutive `wb_write` pulses, correct addresses/data, `in_ready` never drops.
- `rst` pulsed at iteration 30 of a MUL → no `wb_write`, `busy`=0, `in_ready`=1 immediately; following ADD completes normally.
- Opcode 12 → `illegal_op` single-cycle pulse, `wb_write` stays 0; with `ALU_EXEC_MUL_EN` undefined, opcode 10 behaves identically.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared widths, opcode and state enums for the ALU execute stage
package alu_exec_pkg;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10
  } op_e;
  typedef enum logic {S_IDLE, S_MUL} state_e;
endpackage

// File: rtl/alu_exec_if.sv
// alu_exec_if: request (valid/ready, op, operands, dest) and write-back/status bundle; master drives requests, slave is the stage
interface alu_exec_if;
  import alu_exec_pkg::*;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic [ADDR_W-1:0] dest_addr;
  logic              wb_write;
  logic [ADDR_W-1:0] wb_address;
  logic [DATA_W-1:0] wb_data;
  logic              busy;
  logic              illegal_op;
  modport master (
    output in_valid, op, operand_a, operand_b, dest_addr,
    input  in_ready, wb_write, wb_address, wb_data, busy, illegal_op
  );
  modport slave (
    input  in_valid, op, operand_a, operand_b, dest_addr,
    output in_ready, wb_write, wb_address, wb_data, busy, illegal_op
  );
endinterface

// File: rtl/mul_iter.sv
// mul_iter: shift-add multiplier, one multiplier bit per edge; ports clk, rst, start/a/b in, done (on last iteration edge) and low-W product out
module mul_iter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] product
);
  localparam int CW = $clog2(W);
  logic [W-1:0]  mcand, mplier, acc;
  logic [CW-1:0] cnt;
  logic          run;
  // product is the accumulator after the current iteration, so it is final while done is high
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done = run && cnt == CW'(W - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      mcand <= a;
      mplier <= b;
      acc <= '0;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      acc <= product;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 1'b1;
      run <= !done;
    end
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute stage with registered one-cycle write-back; ports clk, rst (async high), bus (alu_exec_if.slave); iterative MUL only with ALU_EXEC_MUL_EN
module alu_exec_stage
  import alu_exec_pkg::*;
(
  input logic       clk,
  input logic       rst,
  alu_exec_if.slave bus
);
  logic [DATA_W-1:0] a, b, res, wb_data;
  logic [ADDR_W-1:0] wb_address;
  logic [5:0]        sh;
  logic              wb_write, illegal_op, accept, simple;
  assign a = bus.operand_a;
  assign b = bus.operand_b;
  assign sh = b[5:0];
  assign simple = bus.op <= OP_SLTU;
  assign accept = bus.in_valid && bus.in_ready;
  assign bus.wb_write = wb_write;
  assign bus.wb_address = wb_address;
  assign bus.wb_data = wb_data;
  assign bus.illegal_op = illegal_op;
  always_comb begin
    res = '0;
    case (bus.op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SLL:  res = a << sh;
      OP_SRL:  res = a >> sh;
      OP_SRA:  res = $signed(a) >>> sh;
      OP_SLT:  res = DATA_W'($signed(a) < $signed(b));
      OP_SLTU: res = DATA_W'(a < b);
      default: res = '0;
    endcase
  end
`ifdef ALU_EXEC_MUL_EN
  state_e            state;
  logic [ADDR_W-1:0] dest_q;
  logic [DATA_W-1:0] mul_product;
  logic              mul_done, is_mul;
  assign is_mul = bus.op == OP_MUL;
  assign bus.in_ready = state == S_IDLE;
  assign bus.busy = state == S_MUL;
  mul_iter #(.W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign bus.in_ready = 1'b1;
  assign bus.busy = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wb_write <= 1'b0;
      wb_address <= '0;
      wb_data <= '0;
      illegal_op <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      state <= S_IDLE;
      dest_q <= '0;
`endif
    end else begin
      wb_write <= 1'b0;
      illegal_op <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      if (state == S_MUL) begin
        if (mul_done) begin
          wb_write <= 1'b1;
          wb_address <= dest_q;
          wb_data <= mul_product;
          state <= S_IDLE;
        end
      end else if (accept && is_mul) begin
        state <= S_MUL;
        dest_q <= bus.dest_addr;
      end else
`endif
      if (accept && simple) begin
        wb_write <= 1'b1;
        wb_address <= bus.dest_addr;
        wb_data <= res;
      end else if (accept)
        illegal_op <= 1'b1;
    end
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: random and directed stimulus checked every cycle against a behavioural model
module tb_alu_exec_stage;
`ifdef ALU_EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  alu_exec_if bus();
  alu_exec_stage dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int          mul_left;
  logic        m_write, m_ill, m_acc;
  logic [4:0]  m_addr, p_addr;
  logic [63:0] m_data, p_data;

  function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    int s;
    logic [63:0] r;
    s = int'(b[5:0]);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << s;
      4'd6: return a >> s;
      4'd7: begin
        r = a >> s;
        if (a[63]) for (int i = 0; i < s; i++) r[63 - i] = 1'b1;
        return r;
      end
      4'd8: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd9: return (a < b) ? 64'd1 : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) begin
      mul_left <= 0;
      m_write <= 1'b0;
      m_ill <= 1'b0;
      m_acc <= 1'b0;
      m_addr <= '0;
      m_data <= '0;
      p_addr <= '0;
      p_data <= '0;
    end else begin
      m_write <= 1'b0;
      m_ill <= 1'b0;
      m_acc <= 1'b0;
      if (mul_left > 0) begin
        mul_left <= mul_left - 1;
        if (mul_left == 1) begin
          m_write <= 1'b1;
          m_addr <= p_addr;
          m_data <= p_data;
        end
      end else if (bus.in_valid) begin
        m_acc <= 1'b1;
        if (bus.op <= 4'd9) begin
          m_write <= 1'b1;
          m_addr <= bus.dest_addr;
          m_data <= ref_alu(bus.op, bus.operand_a, bus.operand_b);
        end else if (bus.op == 4'd10 && MUL_EN) begin
          mul_left <= 64;
          p_addr <= bus.dest_addr;
          p_data <= bus.operand_a * bus.operand_b;
        end else
          m_ill <= 1'b1;
      end
    end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("in_ready", 64'(bus.in_ready), 64'(mul_left == 0));
    chk("busy", 64'(bus.busy), 64'(mul_left != 0));
    chk("wb_write", 64'(bus.wb_write), 64'(m_write));
    chk("illegal_op", 64'(bus.illegal_op), 64'(m_ill));
    chk("wb_address", 64'(bus.wb_address), 64'(m_addr));
    chk("wb_data", bus.wb_data, m_data);
  end

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] d);
    bit got;
    got = 1'b0;
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.dest_addr = d;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      #1;
      got = m_acc;
    end
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 4))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int lo;
    logic [3:0] op;
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.dest_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_wb_data", bus.wb_data, 64'd0);
    chk("rst_wb_write", 64'(bus.wb_write), 64'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    issue(4'd0, '1, 64'd1, 5'd3);
    chk("add_lit_write", 64'(bus.wb_write), 64'd1);
    chk("add_lit_addr", 64'(bus.wb_address), 64'd3);
    chk("add_lit_data", bus.wb_data, 64'd0);
    issue(4'd7, 64'h8000_0000_0000_0000, 64'h43, 5'd4);
    chk("sra_lit", bus.wb_data, 64'hF000_0000_0000_0000);
    issue(4'd8, '1, 64'd0, 5'd5);
    chk("slt_lit", bus.wb_data, 64'd1);
    issue(4'd9, '1, 64'd0, 5'd6);
    chk("sltu_lit", bus.wb_data, 64'd0);
    issue(4'd0, 64'd10, 64'd20, 5'd1);
    chk("b2b_add", bus.wb_data, 64'd30);
    issue(4'd4, 64'hFF00, 64'h0FF0, 5'd2);
    chk("b2b_xor", bus.wb_data, 64'hF0F0);
    issue(4'd1, 64'd5, 64'd7, 5'd0);
    chk("b2b_sub", bus.wb_data, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("b2b_addr0", 64'(bus.wb_address), 64'd0);
    idle();
    issue(4'd12, 64'd1, 64'd1, 5'd9);
    idle();
    chk("ill12_pulse", 64'(bus.illegal_op), 64'd1);
    chk("ill12_nowrite", 64'(bus.wb_write), 64'd0);
    @(negedge clk);
    chk("ill12_end", 64'(bus.illegal_op), 64'd0);
    issue(4'd10, 64'h1_0000_0001, 64'h1_0000_0001, 5'd7);
    idle();
    if (MUL_EN) begin
      lo = 0;
      for (int i = 0; i < 100 && !bus.wb_write; i++) begin
        if (!bus.in_ready) lo++;
        @(negedge clk);
      end
      chk("mul_stall", 64'(lo), 64'd64);
      chk("mul_addr", 64'(bus.wb_address), 64'd7);
      chk("mul_data", bus.wb_data, 64'h2_0000_0001);
      @(negedge clk);
      issue(4'd10, 64'd3, 64'd5, 5'd8);
      idle();
      repeat (29) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_busy", 64'(bus.busy), 64'd0);
      chk("rst_mid_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_mid_write", 64'(bus.wb_write), 64'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      issue(4'd0, 64'd2, 64'd3, 5'd11);
      idle();
      chk("post_rst_add", bus.wb_data, 64'd5);
    end else begin
      chk("mul_off_ill", 64'(bus.illegal_op), 64'd1);
      chk("mul_off_nowrite", 64'(bus.wb_write), 64'd0);
    end
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(negedge clk);
      end else begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'd10 && $urandom_range(0, 3) != 0) op = 4'd0;
        issue(op, rnd64(), rnd64(), 5'($urandom));
      end
    end
    idle();
    repeat (70) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
